// File: rtl/i2c_master_wr.sv
// Single-transaction I2C write engine (START, addr+W, [reg], data, STOP) paced by a
// quarter-bit tick; drives open-drain pull-down enables for SCL and SDA.
module i2c_master_wr #(
    parameter bit REG_EN    = 1'b1,
    parameter bit ACK_CHECK = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_ACK1  = 4'd3;
    localparam logic [3:0] S_REG   = 4'd4;
    localparam logic [3:0] S_ACK2  = 4'd5;
    localparam logic [3:0] S_DATA  = 4'd6;
    localparam logic [3:0] S_ACK3  = 4'd7;
    localparam logic [3:0] S_STOP  = 4'd8;

    logic [3:0] state_reg, state_next;
    logic [1:0] phase_reg, phase_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] addr_byte_reg, addr_byte_next;
    logic [7:0] reg_byte_reg, reg_byte_next;
    logic [7:0] data_byte_reg, data_byte_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       ack_err_reg, ack_err_next;
    logic       scl_oe_reg, scl_oe_next;
    logic       sda_oe_reg, sda_oe_next;
    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       in_ack;
    logic       scl_low_edge;

    assign in_ack = (state_reg == S_ACK1) || (state_reg == S_ACK2) || (state_reg == S_ACK3);

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        bit_cnt_next   = bit_cnt_reg;
        addr_byte_next = addr_byte_reg;
        reg_byte_next  = reg_byte_reg;
        data_byte_next = data_byte_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        ack_err_next   = ack_err_reg;

        if (state_reg == S_IDLE) begin
            if (start) begin
                state_next     = S_START;
                phase_next     = 2'd0;
                bit_cnt_next   = 3'd7;
                addr_byte_next = {dev_addr, 1'b0};
                reg_byte_next  = reg_addr;
                data_byte_next = wr_data;
                busy_next      = 1'b1;
                ack_err_next   = 1'b0;
            end
        end else if (tick) begin
            phase_next = phase_reg + 2'd1;
            if (ACK_CHECK && in_ack && phase_reg == 2'd2 && sda_in) begin
                ack_err_next = 1'b1;
            end
            if (phase_reg == 2'd3) begin
                // ack_err_reg can only be set by a NACK of the current transaction,
                // since it is cleared on accept.
                case (state_reg)
                    S_START: begin
                        state_next   = S_ADDR;
                        bit_cnt_next = 3'd7;
                    end
                    S_ADDR: begin
                        if (bit_cnt_reg == 3'd0) state_next = S_ACK1;
                        else bit_cnt_next = bit_cnt_reg - 3'd1;
                    end
                    S_REG: begin
                        if (bit_cnt_reg == 3'd0) state_next = S_ACK2;
                        else bit_cnt_next = bit_cnt_reg - 3'd1;
                    end
                    S_DATA: begin
                        if (bit_cnt_reg == 3'd0) state_next = S_ACK3;
                        else bit_cnt_next = bit_cnt_reg - 3'd1;
                    end
                    S_ACK1: begin
                        bit_cnt_next = 3'd7;
                        if (ack_err_reg) state_next = S_STOP;
                        else if (REG_EN) state_next = S_REG;
                        else state_next = S_DATA;
                    end
                    S_ACK2: begin
                        bit_cnt_next = 3'd7;
                        state_next   = ack_err_reg ? S_STOP : S_DATA;
                    end
                    S_ACK3: state_next = S_STOP;
                    S_STOP: begin
                        state_next = S_IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (state_next)
            S_ADDR:  tx_byte = addr_byte_next;
            S_REG:   tx_byte = reg_byte_next;
            default: tx_byte = data_byte_next;
        endcase
    end

    assign tx_bit       = tx_byte[bit_cnt_next];
    assign scl_low_edge = (phase_next == 2'd0) || (phase_next == 2'd3);

    // Line levels are decoded from the upcoming state so the pads come straight off flops.
    always_comb begin
        scl_oe_next = 1'b0;
        sda_oe_next = 1'b0;
        case (state_next)
            S_START: begin
                scl_oe_next = (phase_next == 2'd3);
                sda_oe_next = phase_next[1];
            end
            S_ADDR, S_REG, S_DATA: begin
                scl_oe_next = scl_low_edge;
                sda_oe_next = ~tx_bit;
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                scl_oe_next = scl_low_edge;
                sda_oe_next = 1'b0;
            end
            S_STOP: begin
                scl_oe_next = (phase_next == 2'd0);
                sda_oe_next = ~phase_next[1];
            end
            default: begin
                scl_oe_next = 1'b0;
                sda_oe_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            phase_reg     <= 2'd0;
            bit_cnt_reg   <= 3'd7;
            addr_byte_reg <= 8'd0;
            reg_byte_reg  <= 8'd0;
            data_byte_reg <= 8'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
            scl_oe_reg    <= 1'b0;
            sda_oe_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            bit_cnt_reg   <= bit_cnt_next;
            addr_byte_reg <= addr_byte_next;
            reg_byte_reg  <= reg_byte_next;
            data_byte_reg <= data_byte_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ack_err_reg   <= ack_err_next;
            scl_oe_reg    <= scl_oe_next;
            sda_oe_reg    <= sda_oe_next;
        end
    end

    assign scl_oe  = scl_oe_reg;
    assign sda_oe  = sda_oe_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: symbol-level bus model checked every cycle, plus a bus decoder
// whose bytes, START/STOP counts and done timing are pinned to literal values.
module tb_i2c_master_wr;

    localparam int SY_START = 0;
    localparam int SY_B0    = 1;
    localparam int SY_B1    = 2;
    localparam int SY_ACK   = 3;
    localparam int SY_STOP  = 4;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n, tick, start, sda_in, sel;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr, wr_data;
    logic       scl_a, sda_a, busy_a, done_a, err_a;
    logic       scl_b, sda_b, busy_b, done_b, err_b;
    logic [4:0] dut_vec, exp_vec;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    // model state
    int sym[$];
    int tick_cnt = 0;
    bit m_active = 0;
    bit m_done   = 0;
    bit m_err    = 0;
    int mb, mp;

    // bus decoder state
    logic       prev_scl = 1'b0, prev_sda = 1'b0;
    logic [8:0] mon_sh;
    logic [7:0] mon_bytes[$];
    int mon_bc = 0, n_start = 0, n_stop = 0, stop_tick = -1, done_tick = -1;

    always #10 CLOCK_50 = ~CLOCK_50;

    i2c_master_wr #(.REG_EN(1'b1), .ACK_CHECK(1'b1)) u_dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tick(tick), .start(start),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data), .sda_in(sda_in),
        .scl_oe(scl_a), .sda_oe(sda_a), .busy(busy_a), .done(done_a), .ack_err(err_a)
    );

    i2c_master_wr #(.REG_EN(1'b0), .ACK_CHECK(1'b1)) u_dut_noreg (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tick(tick), .start(start),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data), .sda_in(sda_in),
        .scl_oe(scl_b), .sda_oe(sda_b), .busy(busy_b), .done(done_b), .ack_err(err_b)
    );

    assign dut_vec = sel ? {scl_b, sda_b, busy_b, done_b, err_b}
                         : {scl_a, sda_a, busy_a, done_a, err_a};

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [1:0] quarter(input int s, input int p);
        logic lo;
        lo = (p == 0) || (p == 3);
        case (s)
            SY_START: return {p == 3, p >= 2};
            SY_B0:    return {lo, 1'b1};
            SY_B1:    return {lo, 1'b0};
            SY_ACK:   return {lo, 1'b0};
            default:  return {p == 0, p <= 1};
        endcase
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sym.push_back(b[i] ? SY_B1 : SY_B0);
        sym.push_back(SY_ACK);
    endtask

    // quarter-bit enable: one cycle in four
    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            div  = (div + 1) % 4;
            tick = (div == 0);
        end
    end

    // behavioural model: transaction is a list of bit symbols, one per 4 ticks
    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (!rst_n) begin
                m_active = 0;
                m_done   = 0;
                m_err    = 0;
            end else begin
                m_done = 0;
                if (!m_active) begin
                    if (start) begin
                        sym.delete();
                        sym.push_back(SY_START);
                        push_byte({dev_addr, 1'b0});
                        if (!sel) push_byte(reg_addr);
                        push_byte(wr_data);
                        sym.push_back(SY_STOP);
                        m_active = 1;
                        m_err    = 0;
                        tick_cnt = 0;
                    end
                end else if (tick) begin
                    mb = tick_cnt / 4;
                    mp = tick_cnt % 4;
                    if (sym[mb] == SY_ACK && mp == 2 && sda_in) begin
                        m_err = 1;
                        while (sym.size() > mb + 1) void'(sym.pop_back());
                        sym.push_back(SY_STOP);
                    end
                    tick_cnt++;
                    if (tick_cnt == 4 * sym.size()) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
        end
    end

    // per-cycle compare and bus decoder
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (chk_en) begin
                if (m_active)
                    exp_vec = {quarter(sym[tick_cnt / 4], tick_cnt % 4), 1'b1, m_done, m_err};
                else
                    exp_vec = {2'b00, 1'b0, m_done, m_err};
                n_total++;
                if (dut_vec === exp_vec) n_pass++;
                else $display("FAIL cycle t=%0t tick=%0d {scl,sda,busy,done,err}: got %b, expected %b",
                              $time, tick_cnt, dut_vec, exp_vec);

                if (!prev_scl && !dut_vec[4] && !prev_sda && dut_vec[3]) begin
                    n_start++;
                    mon_bc = 0;
                end else if (!prev_scl && !dut_vec[4] && prev_sda && !dut_vec[3]) begin
                    n_stop++;
                    stop_tick = tick_cnt;
                end else if (prev_scl && !dut_vec[4]) begin
                    mon_sh = {mon_sh[7:0], ~dut_vec[3]};
                    mon_bc++;
                    if (mon_bc == 9) begin
                        mon_bytes.push_back(mon_sh[8:1]);
                        mon_bc = 0;
                    end
                end
                if (dut_vec[1]) done_tick = tick_cnt;
                prev_scl = dut_vec[4];
                prev_sda = dut_vec[3];
            end
        end
    end

    task automatic mon_clear();
        mon_bytes.delete();
        mon_bc    = 0;
        n_start   = 0;
        n_stop    = 0;
        stop_tick = -1;
        done_tick = -1;
    endtask

    task automatic do_start(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        @(posedge CLOCK_50);
        #1;
        dev_addr = a;
        reg_addr = r;
        wr_data  = d;
        start    = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while ((busy_a || busy_b || m_active) && n < 2000);
        check({name, "_idle_reached"}, int'(n < 2000), 1);
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic wait_ticks(input int target);
        int n;
        n = 0;
        while (tick_cnt < target && n < 2000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        check("tick_wait", int'(tick_cnt == target), 1);
    endtask

    task automatic check_full(input string name);
        check({name, "_nbytes"}, mon_bytes.size(), 3);
        check({name, "_byte0"}, int'(mon_bytes[0]), 'hA0);
        check({name, "_byte1"}, int'(mon_bytes[1]), 'h10);
        check({name, "_byte2"}, int'(mon_bytes[2]), 'hA5);
        check({name, "_done_tick"}, done_tick, 116);
        check({name, "_stop_tick"}, stop_tick, 114);
        check({name, "_starts"}, n_start, 1);
        check({name, "_stops"}, n_stop, 1);
        check({name, "_ack_err"}, int'(err_a), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        sda_in   = 1'b0;
        sel      = 1'b0;
        dev_addr = 7'h50;
        reg_addr = 8'h10;
        wr_data  = 8'hA5;

        // T1: reset held with start asserted and ticks running
        @(posedge CLOCK_50);
        #1;
        chk_en = 1;
        repeat (3) begin
            @(negedge CLOCK_50);
            check("t1_reset_outputs",
                  int'({scl_a, sda_a, busy_a, done_a, err_a, scl_b, sda_b, busy_b, done_b, err_b}), 0);
        end
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;

        // T2: full write, slave ACKs everything
        mon_clear();
        do_start(7'h50, 8'h10, 8'hA5);
        wait_idle("t2");
        check_full("t2");

        // T3: address NACK aborts straight to STOP
        sda_in = 1'b1;
        mon_clear();
        do_start(7'h50, 8'h10, 8'hA5);
        wait_idle("t3");
        sda_in = 1'b0;
        check("t3_nbytes", mon_bytes.size(), 1);
        check("t3_byte0", int'(mon_bytes[0]), 'hA0);
        check("t3_done_tick", done_tick, 44);
        check("t3_stop_tick", stop_tick, 42);
        check("t3_ack_err", int'(err_a), 1);
        check("t3_stops", n_stop, 1);

        // T4: start pulsed mid-transaction with other data must be ignored
        mon_clear();
        do_start(7'h50, 8'h10, 8'hA5);
        wait_ticks(30);
        dev_addr = 7'h11;
        reg_addr = 8'h22;
        wr_data  = 8'h33;
        start    = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        wait_idle("t4");
        check_full("t4");

        // T5: build without the register byte
        sel = 1'b1;
        mon_clear();
        do_start(7'h3C, 8'hEE, 8'h01);
        wait_idle("t5");
        check("t5_nbytes", mon_bytes.size(), 2);
        check("t5_byte0", int'(mon_bytes[0]), 'h78);
        check("t5_byte1", int'(mon_bytes[1]), 'h01);
        check("t5_done_tick", done_tick, 80);
        check("t5_stop_tick", stop_tick, 78);
        check("t5_ack_err", int'(err_b), 0);
        sel = 1'b0;

        // T6: reset mid-transaction, then a clean full write
        mon_clear();
        do_start(7'h50, 8'h10, 8'hA5);
        wait_ticks(70);
        rst_n = 1'b0;
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        check("t6_released", int'({scl_a, sda_a, busy_a, done_a}), 0);
        repeat (4) @(negedge CLOCK_50);
        mon_clear();
        do_start(7'h50, 8'h10, 8'hA5);
        wait_idle("t6");
        check_full("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
